// File: rtl/noc_pkg.sv
// ============================================================================
//  Module : noc_pkg
//  Brief  : Shared types, field layout and routing helpers for the mesh router.
//  Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package noc_pkg;

    localparam int unsigned NUM_PORTS = 5;
    localparam int unsigned PKT_BITS  = 55;
    localparam int unsigned DATA_BITS = 40;
    localparam int unsigned ADDR_BITS = 4;
    localparam int unsigned HOP_BITS  = 2;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        EAST  = 3'd1,
        WEST  = 3'd2,
        NORTH = 3'd3,
        SOUTH = 3'd4
    } port_e;

    typedef struct packed {
        logic                 pkt_type;
        logic [ADDR_BITS-1:0] src;
        logic [ADDR_BITS-1:0] dest;
        logic                 x_dir;
        logic                 y_dir;
        logic [HOP_BITS-1:0]  x_hop;
        logic [HOP_BITS-1:0]  y_hop;
        logic [DATA_BITS-1:0] data;
    } noc_packet_t;

    // Dimension-ordered routing: exhaust X hops before Y, then deliver locally.
    function automatic port_e route_of(input noc_packet_t pkt);
        port_e dir;
        dir = LOCAL;
        if (pkt.x_hop != '0) begin
            dir = pkt.x_dir ? EAST : WEST;
        end else if (pkt.y_hop != '0) begin
            dir = pkt.y_dir ? NORTH : SOUTH;
        end
        return dir;
    endfunction

    function automatic noc_packet_t hop_update(input noc_packet_t pkt);
        noc_packet_t upd;
        upd = pkt;
        if (pkt.x_hop != '0) begin
            upd.x_hop = pkt.x_hop - HOP_BITS'(1);
        end else if (pkt.y_hop != '0) begin
            upd.y_hop = pkt.y_hop - HOP_BITS'(1);
        end
        return upd;
    endfunction

    function automatic port_e port_add(input port_e base, input int unsigned ofs);
        return port_e'(3'((32'(base) + ofs) % NUM_PORTS));
    endfunction

endpackage

`default_nettype wire

// File: rtl/noc_in_fifo.sv
// ============================================================================
//  Module : noc_in_fifo
//  Brief  : Count-based valid/ready input FIFO with head peek and pop.
//  Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module noc_in_fifo #(
    parameter int unsigned DATA_W = 55,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_valid_i,
    input  logic [DATA_W-1:0] push_data_i,
    output logic              push_ready_o,
    input  logic              pop_i,
    output logic              head_valid_o,
    output logic [DATA_W-1:0] head_data_o
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push;
    logic              pop;

    // Ready looks only at the registered count, so a full FIFO refuses a push
    // even in the cycle it pops.
    assign push_ready_o = rst_n && (count_q != FULL_CNT);
    assign head_valid_o = (count_q != '0);
    assign head_data_o  = mem_q[rd_ptr_q];
    assign push         = push_valid_i && push_ready_o;
    assign pop          = pop_i && head_valid_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/noc_mesh_router.sv
// ============================================================================
//  Module : noc_mesh_router
//  Brief  : 5-port XY mesh router with input FIFOs, per-output round-robin
//           arbitration and registered valid/ready outputs.
//  Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module noc_mesh_router
    import noc_pkg::*;
#(
    parameter int unsigned PACKET_WIDTH = 55,
    parameter int unsigned DATA_WIDTH   = 40,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned HOP_WIDTH    = 2,
    parameter int unsigned FIFO_DEPTH   = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_PORTS-1:0]              in_valid,
    output logic [NUM_PORTS-1:0]              in_ready,
    input  logic [NUM_PORTS*PACKET_WIDTH-1:0] in_data,
    output logic [NUM_PORTS-1:0]              out_valid,
    input  logic [NUM_PORTS-1:0]              out_ready,
    output logic [NUM_PORTS*PACKET_WIDTH-1:0] out_data
);

    if ((PACKET_WIDTH != PKT_BITS) || (DATA_WIDTH != DATA_BITS) ||
        (ADDR_WIDTH != ADDR_BITS) || (HOP_WIDTH != HOP_BITS) ||
        (FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_cfg_check
        $error("noc_mesh_router: unsupported parameter set");
    end

    noc_packet_t [NUM_PORTS-1:0]                 head;
    logic        [NUM_PORTS-1:0]                 head_valid;
    port_e                                       route [NUM_PORTS];
    logic        [NUM_PORTS-1:0][NUM_PORTS-1:0]  grant;
    logic        [NUM_PORTS-1:0]                 pop;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
        noc_in_fifo #(
            .DATA_W (PACKET_WIDTH),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk          (clk),
            .rst_n        (rst_n),
            .push_valid_i (in_valid[p]),
            .push_data_i  (in_data[p*PACKET_WIDTH +: PACKET_WIDTH]),
            .push_ready_o (in_ready[p]),
            .pop_i        (pop[p]),
            .head_valid_o (head_valid[p]),
            .head_data_o  (head[p])
        );

        assign route[p] = route_of(head[p]);
    end

    // A head has exactly one route, so at most one output row can grant it.
    always_comb begin
        pop = '0;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            pop = pop | grant[o];
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        localparam logic [2:0] OUT_IDX = 3'(o);

        logic [NUM_PORTS-1:0] req;
        logic [NUM_PORTS-1:0] gnt;
        port_e                win;
        port_e                cand;
        port_e                ptr_q, ptr_d;
        logic                 win_found;
        logic                 load;
        logic                 out_valid_q, out_valid_d;
        noc_packet_t          out_data_q, out_data_d;

        always_comb begin
            req         = '0;
            gnt         = '0;
            win         = LOCAL;
            cand        = LOCAL;
            win_found   = 1'b0;
            load        = 1'b0;
            ptr_d       = ptr_q;
            out_valid_d = out_valid_q;
            out_data_d  = out_data_q;

            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                req[i] = head_valid[i] && (route[i] == OUT_IDX);
            end

            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                cand = port_add(ptr_q, k);
                if (!win_found && req[cand]) begin
                    win       = cand;
                    win_found = 1'b1;
                end
            end

            // The pointer only advances when the packet actually moves.
            load = win_found && (!out_valid_q || out_ready[o]);
            if (load) begin
                gnt         = NUM_PORTS'(1) << win;
                out_valid_d = 1'b1;
                out_data_d  = hop_update(head[win]);
                ptr_d       = port_add(win, 1);
            end else if (out_ready[o]) begin
                out_valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                ptr_q       <= LOCAL;
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
            end else begin
                ptr_q       <= ptr_d;
                out_valid_q <= out_valid_d;
                out_data_q  <= out_data_d;
            end
        end

        assign grant[o]                                    = gnt;
        assign out_valid[o]                                = out_valid_q;
        assign out_data[o*PACKET_WIDTH +: PACKET_WIDTH]    = out_data_q;
    end

endmodule

`default_nettype wire

// File: doc/noc_mesh_router.md
Name: noc_mesh_router

Overview:
- Clocked 5-port 2D-mesh router node. It delivers 55-bit NoC packets to the local PE's depacketizer and accepts result packets from the local PE's packetizer.
- Routes by the hop fields in the packet header, X dimension first, then Y.
- Per-port input FIFOs, per-output round-robin arbitration, registered outputs with valid/ready handshake.
- One instance per mesh tile, sitting between the PE packet interface and its four mesh neighbours.

Parameters:
- PACKET_WIDTH, 55, total packet bits.
- DATA_WIDTH, 40, payload bits [39:0].
- ADDR_WIDTH, 4, source and destination field width.
- HOP_WIDTH, 2, x_hop and y_hop field width.
- FIFO_DEPTH, 2, entries per input FIFO; power of two, ≥2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  5  per-port packet valid. Index: 0=local, 1=east, 2=west, 3=north, 4=south.
- in_ready  out  5  per-port FIFO-not-full.
- in_data  in  5*PACKET_WIDTH  port p occupies bits [p*55 +: 55].
- out_valid  out  5  per-port output register holds a packet.
- out_ready  in  5  downstream accepts.
- out_data  out  5*PACKET_WIDTH  same indexing as in_data.

Behaviour:
- Header fields:
  - [54] type (1=ifmap, 0=filter/psum)
  - [53:50] source
  - [49:46] dest
  - [45] x_dir (1=east, 0=west)
  - [44] y_dir (1=north, 0=south)
  - [43:42] x_hop
  - [41:40] y_hop
  - [39:0] data
- Reset (rst_n low at a clk edge): FIFOs emptied, out_valid=0, out_data=0, all arbiter pointers=0. in_ready=0 while rst_n low, and 1 on the first cycle after release. Reset mid-transfer discards all buffered packets.
- Input handshake: a beat transfers when in_valid[p] && in_ready[p] at a clk edge.
  - in_ready[p] = (count[p] != FIFO_DEPTH), from registered count only. No push-while-full, even if a pop occurs that cycle.
  - Sender holds in_data stable while in_valid && !in_ready.
- Route computation on each FIFO head:
  - x_hop != 0: output east if x_dir=1, else west. Forwarded packet has x_hop-1.
  - else y_hop != 0: output north if y_dir=1, else south. Forwarded packet has y_hop-1.
  - else: output local, header unchanged.
  - All other fields pass through bit-exact. No U-turn check; route depends only on the header, not on the arrival port (local-in with zero hops loops back to local-out).
- Arbitration per output o:
  - Requesters are inputs whose head routes to o.
  - Round-robin search starts at ptr[o]. On a grant, ptr[o] becomes winner+1 mod 5. ptr[o] is unchanged when there is no grant.
- Output register o is loadable when !out_valid[o] || out_ready[o]. On load: out_data[o] <= modified head, out_valid[o] <= 1, winner FIFO pops.
  - If not loadable, the head stays and no pointer moves.
  - out_valid[o] drops only when out_ready[o] is high and nothing new is loaded.
  - out_data is unchanged while out_valid && !out_ready.
- Latency: a packet pushed at edge N is out_valid at edge N+1 if uncontended and the output is free. Throughput is 1 packet/cycle per output; up to 5 packets/cycle in aggregate.
- An input pops at most once per cycle. Each head has a single route, so at most one output grants it.
- Simultaneous push and pop on a non-full FIFO: count unchanged, ordering preserved (FIFO order per input).
- Each FIFO uses wrap-around pointers modulo FIFO_DEPTH.
- No packet is dropped or duplicated under arbitrary out_ready backpressure.

Decomposition:
- Package noc_pkg:
  - port index enum (LOCAL, EAST, WEST, NORTH, SOUTH)
  - packed struct noc_packet_t with the field layout above
  - width constants
  - function route_of(noc_packet_t) returning the port index
  - function hop_update(noc_packet_t) returning the decremented packet
- Sub-module noc_in_fifo: parameterized valid/ready FIFO with count-based full, head peek and pop. Instantiated 5 times.
- Arbiter and output-register logic are generated per output inside the top module.

Test Plan:
- Reset then local inject: x_dir=1, x_hop=2, y_hop=1, data=40'h00_1234_5678 -> east out_valid one cycle after accept, x_hop=1, y_hop=1, other bits identical.
- Zero-hop packet on north input, data=40'hFF -> local output, header unchanged, latency 1 cycle.
- Inputs 1, 2, 3 all target local simultaneously with out_ready=1 -> grant order 1, 2, 3 over three cycles. Next simultaneous round starts at port 4 and wraps: 1, 2, 3.
- out_ready[east]=0 for 6 cycles while local sends 4 east-bound packets -> out_valid held with first packet; local in_ready drops after FIFO full (2 buffered + 1 in register). Release -> 4 packets emerge in order, none lost.
- y-only route: x_hop=0, y_hop=3, y_dir=0 -> south output with y_hop=2. Same packet with y_dir=1 -> north.
- Assert rst_n low for 1 cycle with 2 packets buffered and out_valid=1 -> next cycle all out_valid=0, out_data=0, in_ready=0. After release in_ready=5'b11111 and no stale packet ever appears.
